// File: rtl/qdec_pkg.sv
// Shared types and Gray-code direction decode for the quadrature step decoder.
package qdec_pkg;

    typedef logic [1:0] ab_t;

    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_01 = 2'b01;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_10 = 2'b10;

    typedef struct packed {
        logic step;
        logic up;
        logic illegal;
    } dir_t;

    // Position along the up sequence 00->01->11->10.
    function automatic logic [1:0] gray_pos(input ab_t ab);
        logic [1:0] pos;
        case (ab)
            AB_00:   pos = 2'd0;
            AB_01:   pos = 2'd1;
            AB_11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic dir_t qdec_dir(input ab_t old_ab, input ab_t new_ab);
        dir_t       d;
        logic [1:0] delta;
        d     = '0;
        delta = gray_pos(new_ab) - gray_pos(old_ab);
        case (delta)
            2'd1:    begin d.step = 1'b1; d.up = 1'b1; end
            2'd3:    d.step = 1'b1;
            2'd2:    d.illegal = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Two-channel synchroniser plus stability filter; ab_q updates with a one-cycle accept strobe.
module qdec_sync_filter
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    output ab_t  ab_q,
    output logic accept,
    output logic quiet
);

    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    ab_t                    ab_s;
    ab_t                    ab_p;
    logic [CW-1:0]          cnt;

    assign ab_s  = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign quiet = (ab_s == ab_p) && (ab_s == ab_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            ab_p   <= AB_00;
            ab_q   <= AB_00;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
            ab_p   <= ab_s;
            accept <= 1'b0;
            // A change in ab_s restarts the stability window.
            if ((ab_s != ab_p) || (ab_s == ab_q)) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                cnt    <= '0;
                ab_q   <= ab_s;
                accept <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to step enable/direction converter with illegal-transition flag.
// Optional QDEC_ERR_CNT_EN adds an 8-bit saturating err_cnt output.
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_in,
    input  logic       b_in,
    output logic       enable,
    output logic       up,
    output logic       err
`ifdef QDEC_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    ab_t           ab_q;
    ab_t           ab_d;
    logic          accept;
    logic          quiet;
    logic          primed;
    logic [CW-1:0] prime_cnt;
    dir_t          dir;
    logic          bad_step;

    qdec_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .ab_q  (ab_q),
        .accept(accept),
        .quiet (quiet)
    );

    // ab_d lags ab_q by one cycle, so during accept it holds the pre-accept value.
    assign dir      = qdec_dir(ab_d, ab_q);
    assign bad_step = primed && accept && dir.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_d      <= AB_00;
            primed    <= 1'b0;
            prime_cnt <= '0;
            enable    <= 1'b0;
            up        <= 1'b0;
            err       <= 1'b0;
        end else begin
            ab_d   <= ab_q;
            enable <= 1'b0;
            err    <= 1'b0;
            if (!primed) begin
                if (accept) begin
                    primed <= 1'b1;
                end else if (quiet) begin
                    if (prime_cnt == CW'(FILT_LEN - 1)) primed <= 1'b1;
                    else prime_cnt <= prime_cnt + 1'b1;
                end else begin
                    prime_cnt <= '0;
                end
            end else if (accept) begin
                enable <= dir.step;
                err    <= dir.illegal;
                if (dir.step) up <= dir.up;
            end
        end
    end

`ifdef QDEC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (bad_step && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
